kd_tree_ctrl: RTL and testbench
===============================

// Module: kd_tree_ctrl
// PURPOSE
//  Sequencer for internal_node_tree. LOAD: streams NUM_NODES node configs (idx|median words)
//  into the tree write port. QUERY: issues patches and collects leaf indices into a result
//  FIFO. The tree has no backpressure, so issue is credit-gated (FIFO space vs in-flight).
//  Sits between the input loader/host streams and the tree.
// PARAMETERS
//  INTERNAL_WIDTH  22  node config word width (idx in [2:0], median in [21:11])
//  PATCH_WIDTH     55  patch width (5 x 11-bit components)
//  ADDRESS_WIDTH   8   leaf index width
//  NUM_NODES       63  config words per load (tree internal node count)
//  RESULT_DEPTH    8   result FIFO entries (power of 2)
// PORTS
//  clk              in   1    clock
//  rst_n            in   1    async active-low reset
//  start            in   1    begin load; honoured only in IDLE
//  query_end        in   1    no more patches; honoured only in QUERY
//  cfg_valid        in   1    config word valid
//  cfg_data         in   22   config word
//  cfg_ready        out  1    config accept
//  patch_valid      in   1    patch valid
//  patch_data       in   55   patch
//  patch_ready      out  1    patch accept
//  fsm_enable       out  1    to tree; high in LOAD
//  sender_enable    out  1    to tree; one-cycle write strobe
//  sender_data      out  22   to tree; config word
//  patch_en         out  1    to tree; patch strobe
//  patch_out        out  55   to tree; patch
//  tree_receiver_en in   1    from tree; leaf valid
//  tree_leaf_index  in   8    from tree; leaf index
//  leaf_valid       out  1    result FIFO non-empty
//  leaf_index       out  8    FIFO head
//  leaf_ready       in   1    consumer pop
//  done             out  1    high in DONE
//  err              out  1    sticky protocol error
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, counters/FIFO cleared, every output 0.
//  States: IDLE -start-> LOAD -NUM_NODES-th cfg handshake-> QUERY -query_end-> DRAIN
//   -(inflight==0 && FIFO empty)-> DONE. DONE holds until reset. The tree write address
//   only clears on reset, so reload requires reset.
//  LOAD: cfg_ready=1. fsm_enable=1 in LOAD and on the cycle after the final handshake.
//   Handshake = cfg_valid&&cfg_ready. Handshake at cycle T -> sender_enable=1 and
//   sender_data=cfg_data at T+1 (registered). Write order = arrival order. 6-bit load_cnt
//   reaches NUM_NODES, then state=QUERY at T+1. cfg_valid outside LOAD is ignored.
//  QUERY: patch_ready = (fifo_count+inflight < RESULT_DEPTH); combinational, no dependency
//   on patch_valid. Accept at T -> patch_en=1, patch_out=patch_data at T+1. The tree adds
//   6 cycles, so tree_receiver_en arrives at T+7. Controller does not rely on this value;
//   it counts strobes. Entry is written at T+7 edge; leaf_valid at T+8.
//  inflight: +1 on accept, -1 on tree_receiver_en; both same cycle -> unchanged.
//  FIFO: push on tree_receiver_en, pop on leaf_valid&&leaf_ready; simultaneous push+pop on
//   non-empty -> count unchanged, order preserved. Push never finds the FIFO full (credit
//   rule). Pointers wrap modulo RESULT_DEPTH.
//  query_end and accept in the same cycle: patch accepted, then DRAIN. patch_ready=0 in
//   DRAIN/DONE. leaf_valid/pop continue in DRAIN and DONE.
//  err sticky (reset only): tree_receiver_en with inflight==0, or push when FIFO full.
//  Reset mid-operation: immediate return to IDLE; any partial load is abandoned.
// TESTING
//  Reset: hold rst_n=0 async mid-cycle -> all outputs 0, state IDLE. Assert start during
//   reset -> ignored.
//  Load: start, then 63 words 0..62 with cfg_valid low every 3rd cycle -> exactly 63
//   sender_enable pulses, data in order, QUERY one cycle after the 63rd handshake.
//  Latency: accept one patch at cycle 0 -> patch_en at 1. Tree model returns leaf 0x2A at
//   cycle 7 -> leaf_valid=1, leaf_index=0x2A at cycle 8.
//  Credit: leaf_ready=0, patch_valid held 12 cycles -> exactly 8 accepts, then
//   patch_ready=0. Pop one -> exactly one more accept.
//  Concurrency: back-to-back patches, leaf_ready=1 -> push+pop same cycle, FIFO count
//   stable, results in order, err=0.
//  Drain: query_end with 3 in flight -> DRAIN, done=1 only after 3 results popped. Inject a
//   spurious tree_receiver_en -> err=1 and stays 1.

Source files
------------

// File: rtl/kd_tree_ctrl_if.sv
// Signal bundle between kd_tree_ctrl and its host streams and tree.
// The controller uses the slave modport. The host/tree side uses the master modport.
interface kd_tree_ctrl_if #(
    parameter int unsigned INTERNAL_WIDTH = 22,
    parameter int unsigned PATCH_WIDTH    = 55,
    parameter int unsigned ADDRESS_WIDTH  = 8
);
    logic                      start;
    logic                      query_end;
    logic                      cfg_valid;
    logic [INTERNAL_WIDTH-1:0] cfg_data;
    logic                      cfg_ready;
    logic                      patch_valid;
    logic [PATCH_WIDTH-1:0]    patch_data;
    logic                      patch_ready;
    logic                      fsm_enable;
    logic                      sender_enable;
    logic [INTERNAL_WIDTH-1:0] sender_data;
    logic                      patch_en;
    logic [PATCH_WIDTH-1:0]    patch_out;
    logic                      tree_receiver_en;
    logic [ADDRESS_WIDTH-1:0]  tree_leaf_index;
    logic                      leaf_valid;
    logic [ADDRESS_WIDTH-1:0]  leaf_index;
    logic                      leaf_ready;
    logic                      done;
    logic                      err;

    modport slave (
        input  start, query_end, cfg_valid, cfg_data, patch_valid, patch_data,
               tree_receiver_en, tree_leaf_index, leaf_ready,
        output cfg_ready, patch_ready, fsm_enable, sender_enable, sender_data,
               patch_en, patch_out, leaf_valid, leaf_index, done, err
    );

    modport master (
        output start, query_end, cfg_valid, cfg_data, patch_valid, patch_data,
               tree_receiver_en, tree_leaf_index, leaf_ready,
        input  cfg_ready, patch_ready, fsm_enable, sender_enable, sender_data,
               patch_en, patch_out, leaf_valid, leaf_index, done, err
    );
endinterface

// File: rtl/kd_tree_ctrl.sv
// Load/query sequencer for internal_node_tree.
// It streams node configs into the tree, issues patches credit-gated, and buffers leaf results in a FIFO.
module kd_tree_ctrl #(
    parameter int unsigned INTERNAL_WIDTH = 22,
    parameter int unsigned PATCH_WIDTH    = 55,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned NUM_NODES      = 63,
    parameter int unsigned RESULT_DEPTH   = 8
) (
    input logic           clk,
    input logic           rst_n,
    kd_tree_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(NUM_NODES + 1);
    localparam int unsigned PTR_W = $clog2(RESULT_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_QUERY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          load_cnt_q, load_cnt_d;
    logic [OCC_W-1:0]          inflight_q, inflight_d;
    logic [OCC_W-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic                      fin_q;
    logic                      sender_en_q;
    logic [INTERNAL_WIDTH-1:0] sender_data_q;
    logic                      patch_en_q;
    logic [PATCH_WIDTH-1:0]    patch_out_q;
    logic                      err_q, err_d;
    logic [ADDRESS_WIDTH-1:0]  mem [RESULT_DEPTH];

    logic cfg_hs, last_cfg, credit_ok, patch_rdy, accept;
    logic fifo_full, fifo_empty, pop, push, ret_ok;

    // Credit covers both buffered results and patches still inside the tree.
    // A push therefore always finds a free FIFO slot.
    assign credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < (OCC_W + 1)'(RESULT_DEPTH);
    assign cfg_hs     = bus.cfg_valid && (state_q == S_LOAD);
    assign last_cfg   = cfg_hs && (load_cnt_q == CNT_W'(NUM_NODES - 1));
    assign patch_rdy  = (state_q == S_QUERY) && credit_ok;
    assign accept     = bus.patch_valid && patch_rdy;
    assign fifo_full  = (fifo_cnt_q == OCC_W'(RESULT_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = !fifo_empty && bus.leaf_ready;
    assign push       = bus.tree_receiver_en && (!fifo_full || pop);
    assign ret_ok     = bus.tree_receiver_en && (inflight_q != '0);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD: begin
                if (cfg_hs) load_cnt_d = load_cnt_q + CNT_W'(1);
                if (last_cfg) state_d = S_QUERY;
            end
            S_QUERY: if (bus.query_end) state_d = S_DRAIN;
            S_DRAIN: if ((inflight_q == '0) && fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !ret_ok)      inflight_d = inflight_q + OCC_W'(1);
        else if (!accept && ret_ok) inflight_d = inflight_q - OCC_W'(1);

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + OCC_W'(1);
        else if (pop && !push) fifo_cnt_d = fifo_cnt_q - OCC_W'(1);

        err_d = err_q
              | (bus.tree_receiver_en && (inflight_q == '0))
              | (bus.tree_receiver_en && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            inflight_q    <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fin_q         <= 1'b0;
            sender_en_q   <= 1'b0;
            sender_data_q <= '0;
            patch_en_q    <= 1'b0;
            patch_out_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fin_q       <= last_cfg;
            sender_en_q <= cfg_hs;
            patch_en_q  <= accept;
            err_q       <= err_d;
            if (cfg_hs) sender_data_q <= bus.cfg_data;
            if (accept) patch_out_q <= bus.patch_data;
            if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.tree_leaf_index;
    end

    assign bus.cfg_ready     = (state_q == S_LOAD);
    assign bus.fsm_enable    = (state_q == S_LOAD) || fin_q;
    assign bus.sender_enable = sender_en_q;
    assign bus.sender_data   = sender_data_q;
    assign bus.patch_ready   = patch_rdy;
    assign bus.patch_en      = patch_en_q;
    assign bus.patch_out     = patch_out_q;
    assign bus.leaf_valid    = !fifo_empty;
    assign bus.leaf_index    = fifo_empty ? '0 : mem[rd_ptr_q];
    assign bus.done          = (state_q == S_DONE);
    assign bus.err           = err_q;
endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Scoreboard bench for kd_tree_ctrl.
// A behavioural tree returns f(patch) six cycles after patch_en, and a monitor pops expected values.
module tb_kd_tree_ctrl;
    localparam int unsigned IW = 22;
    localparam int unsigned PW = 55;
    localparam int unsigned AW = 8;
    localparam int unsigned NN = 63;
    localparam int unsigned RD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    kd_tree_ctrl_if #(.INTERNAL_WIDTH(IW), .PATCH_WIDTH(PW), .ADDRESS_WIDTH(AW)) bus();

    kd_tree_ctrl #(
        .INTERNAL_WIDTH(IW), .PATCH_WIDTH(PW), .ADDRESS_WIDTH(AW),
        .NUM_NODES(NN), .RESULT_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int spur_cyc = -1;
    int sender_pulses = 0;
    int push_pop_seen = 0;
    logic [IW-1:0] exp_cfg[$];
    logic [PW-1:0] exp_patch[$];
    logic [AW-1:0] exp_leaf[$];
    bit hs, acc;

    function automatic logic [AW-1:0] leaf_of(input logic [PW-1:0] p);
        return p[7:0] ^ p[18:11];
    endfunction

    function automatic logic [PW-1:0] rand_patch();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural tree: fixed six-cycle pipeline from patch_en to leaf strobe.
    initial begin
        int due[$];
        logic [AW-1:0] lf[$];
        bus.tree_receiver_en = 1'b0;
        bus.tree_leaf_index  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (due.size() > 0 && due[0] == cyc) begin
                bus.tree_receiver_en = 1'b1;
                bus.tree_leaf_index  = lf.pop_front();
                void'(due.pop_front());
            end else if (spur_cyc == cyc) begin
                bus.tree_receiver_en = 1'b1;
                bus.tree_leaf_index  = 8'h55;
            end else begin
                bus.tree_receiver_en = 1'b0;
                bus.tree_leaf_index  = '0;
            end
            @(negedge clk);
            if (bus.patch_en) begin
                due.push_back(cyc + 6);
                lf.push_back(leaf_of(bus.patch_out));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.sender_enable) begin
                sender_pulses++;
                if (exp_cfg.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sender_extra: got %0h expected none", bus.sender_data);
                end else chk("sender_data", 64'(bus.sender_data), 64'(exp_cfg.pop_front()));
            end
            if (bus.patch_en) begin
                if (exp_patch.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL patch_extra: got %0h expected none", bus.patch_out);
                end else chk("patch_out", 64'(bus.patch_out), 64'(exp_patch.pop_front()));
            end
            if (bus.leaf_valid && bus.leaf_ready) begin
                if (exp_leaf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL leaf_extra: got %0h expected none", bus.leaf_index);
                end else chk("leaf_index", 64'(bus.leaf_index), 64'(exp_leaf.pop_front()));
            end
            if (bus.tree_receiver_en && bus.leaf_valid && bus.leaf_ready) push_pop_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic neg();
        @(negedge clk);
        hs  = bus.cfg_valid && bus.cfg_ready;
        acc = bus.patch_valid && bus.patch_ready;
        if (hs) exp_cfg.push_back(bus.cfg_data);
        if (acc) begin
            exp_patch.push_back(bus.patch_data);
            exp_leaf.push_back(leaf_of(bus.patch_data));
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) begin neg(); pos(); end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cfg_ready"},   64'(bus.cfg_ready), 0);
        chk({tag, "_patch_ready"}, 64'(bus.patch_ready), 0);
        chk({tag, "_fsm_enable"},  64'(bus.fsm_enable), 0);
        chk({tag, "_sender_en"},   64'(bus.sender_enable), 0);
        chk({tag, "_sender_data"}, 64'(bus.sender_data), 0);
        chk({tag, "_patch_en"},    64'(bus.patch_en), 0);
        chk({tag, "_leaf_valid"},  64'(bus.leaf_valid), 0);
        chk({tag, "_leaf_index"},  64'(bus.leaf_index), 0);
        chk({tag, "_done"},        64'(bus.done), 0);
        chk({tag, "_err"},         64'(bus.err), 0);
    endtask

    initial begin
        int w, k, acc_cnt, n;
        logic [31:0] r;
        bus.start = 1'b1;
        bus.query_end = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data = '0;
        bus.patch_valid = 1'b0;
        bus.patch_data = '0;
        bus.leaf_ready = 1'b0;

        // Reset with start held high: outputs zero, start ignored.
        #8;
        chk_zero("reset");
        pos();
        rst_n = 1'b1;
        bus.start = 1'b0;
        neg(); chk("idle_after_reset", 64'(bus.cfg_ready), 0); pos();
        idle(2);
        neg(); chk("idle_fsm_enable", 64'(bus.fsm_enable), 0); pos();

        // Partial load, then async reset in mid-cycle.
        bus.start = 1'b1; neg(); pos(); bus.start = 1'b0;
        neg(); chk("load_cfg_ready", 64'(bus.cfg_ready), 1); chk("load_fsm_enable", 64'(bus.fsm_enable), 1); pos();
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            bus.cfg_valid = 1'b1; bus.cfg_data = r[IW-1:0];
            neg(); pos();
        end
        bus.cfg_valid = 1'b0;
        idle(3);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        pos();
        rst_n = 1'b1;
        neg(); chk("post_reset_idle", 64'(bus.cfg_ready), 0); pos();

        // Full load, 0..62 with valid low every third cycle.
        bus.start = 1'b1; neg(); pos(); bus.start = 1'b0;
        w = 0; k = 0;
        while (w < int'(NN) && k < 400) begin
            r = $urandom_range(0, 2047);
            bus.cfg_valid = (k % 3 != 2);
            bus.cfg_data = IW'((r << 11) | 32'(w));
            neg();
            if (hs) w++;
            pos();
            k++;
        end
        bus.cfg_valid = 1'b0;
        chk("load_words", 64'(w), 64'(NN));
        neg();
        chk("fsm_en_after_last", 64'(bus.fsm_enable), 1);
        chk("query_entered", 64'(bus.patch_ready), 1);
        chk("query_cfg_ready", 64'(bus.cfg_ready), 0);
        pos();
        neg(); chk("fsm_en_drop", 64'(bus.fsm_enable), 0); pos();

        // Latency: single patch producing leaf 0x2A.
        bus.patch_valid = 1'b1; bus.patch_data = PW'(8'h2A);
        neg(); chk("lat_patch_ready", 64'(bus.patch_ready), 1); pos();
        bus.patch_valid = 1'b0;
        neg(); chk("lat_patch_en", 64'(bus.patch_en), 1); pos();
        for (int c = 2; c <= 7; c++) begin
            neg();
            if (c == 2) chk("lat_patch_en_pulse", 64'(bus.patch_en), 0);
            if (c == 7) chk("lat_not_early", 64'(bus.leaf_valid), 0);
            pos();
        end
        neg();
        chk("lat_leaf_valid", 64'(bus.leaf_valid), 1);
        chk("lat_leaf_index", 64'(bus.leaf_index), 64'h2A);
        pos();
        bus.leaf_ready = 1'b1; neg(); pos(); bus.leaf_ready = 1'b0;
        neg(); chk("lat_popped", 64'(bus.leaf_valid), 0); pos();

        // Credit: hold patch_valid with no consumer.
        acc_cnt = 0;
        bus.patch_valid = 1'b1; bus.patch_data = rand_patch();
        for (int i = 0; i < 12; i++) begin
            neg(); if (acc) acc_cnt++; pos();
            if (acc) bus.patch_data = rand_patch();
        end
        bus.patch_valid = 1'b0;
        chk("credit_accepts", 64'(acc_cnt), 64'(RD));
        idle(8);
        neg(); chk("credit_full", 64'(bus.patch_ready), 0); chk("credit_leaf_valid", 64'(bus.leaf_valid), 1); pos();
        acc_cnt = 0;
        bus.patch_valid = 1'b1; bus.leaf_ready = 1'b1;
        neg(); if (acc) acc_cnt++; pos();
        bus.leaf_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            neg(); if (acc) acc_cnt++; pos();
            if (acc) bus.patch_data = rand_patch();
        end
        bus.patch_valid = 1'b0;
        chk("credit_one_more", 64'(acc_cnt), 1);
        bus.leaf_ready = 1'b1;
        idle(20);
        neg(); chk("credit_drained", 64'(bus.leaf_valid), 0); pos();

        // Concurrency: streaming patches with an always-ready consumer.
        push_pop_seen = 0;
        bus.patch_valid = 1'b1; bus.patch_data = rand_patch();
        for (int i = 0; i < 40; i++) begin
            neg(); chk("conc_err", 64'(bus.err), 0); pos();
            if (acc) bus.patch_data = rand_patch();
        end
        bus.patch_valid = 1'b0;
        idle(12);
        neg();
        chk("conc_push_pop", 64'(push_pop_seen != 0), 1);
        chk("conc_drained", 64'(bus.leaf_valid), 0);
        pos();

        // Drain: query_end alongside the third accepted patch.
        bus.leaf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.patch_valid = 1'b1; bus.patch_data = rand_patch();
            bus.query_end = (i == 2);
            neg(); chk("drain_accept", 64'(bus.patch_ready), 1); pos();
        end
        bus.patch_valid = 1'b0; bus.query_end = 1'b0;
        neg(); chk("drain_no_ready", 64'(bus.patch_ready), 0); chk("drain_not_done", 64'(bus.done), 0); pos();
        idle(10);
        neg(); chk("drain_hold_full", 64'(bus.done), 0); chk("drain_leaf_valid", 64'(bus.leaf_valid), 1); pos();
        bus.leaf_ready = 1'b1;
        n = 0;
        while (n < 20) begin
            neg();
            if (bus.leaf_valid) chk("done_early", 64'(bus.done), 0);
            if (bus.done) break;
            pos();
            n++;
        end
        chk("done_reached", 64'(bus.done), 1);
        chk("err_clear_before", 64'(bus.err), 0);
        pos();

        // Spurious leaf strobe with nothing in flight.
        exp_leaf.push_back(8'h55);
        spur_cyc = cyc + 1;
        idle(4);
        neg(); chk("err_set", 64'(bus.err), 1); chk("done_holds", 64'(bus.done), 1); pos();
        idle(5);
        neg(); chk("err_sticky", 64'(bus.err), 1); chk("final_empty", 64'(bus.leaf_valid), 0); pos();

        chk("exp_cfg_left", 64'(exp_cfg.size()), 0);
        chk("exp_patch_left", 64'(exp_patch.size()), 0);
        chk("exp_leaf_left", 64'(exp_leaf.size()), 0);
        chk("sender_pulses", 64'(sender_pulses), 64'(NN + 5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
